ldl_fifo_rd_arb: RTL and testbench
==================================

# ldl_fifo_rd_arb

Round-robin read scheduler that shares one downstream valid/ready consumer between N FIFO read-sides. It grants one FIFO at a time for a bounded burst and drives that FIFO's `re`. It absorbs the one-cycle RAM read latency in a 2-entry output buffer, so backpressure never loses a word. It sits between the read-side controllers of N independent FIFOs and a single egress stream tagged with its source index.

## Interface
- `N`, 4: number of FIFO read-sides, ≥2.
- `DW`, 32: data width.
- `BURST`, 4: maximum words issued per grant, ≥1.
- `SW`, $clog2(N): source-index width (derived, not overridden).

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `empty`  in  N  per-FIFO empty flag. Registered by the FIFO read-side; deasserts with one cycle delay after a write.
- `re`  out  N  per-FIFO read enable. One-hot or zero.
- `rdata`  in  N×DW  per-FIFO RAM read data. Valid the cycle after the matching `re`.
- `out_valid`  out  1  egress word valid.
- `out_ready`  in  1  egress accept.
- `out_data`  out  DW  egress word.
- `out_src`  out  SW  index of the FIFO that supplied `out_data`.

## Operation
- **FSM states: IDLE, BURST.**
  - In IDLE, scan `empty` starting at `rr_ptr`, wrapping modulo N. Select the first FIFO with `empty`=0 and register it as `sel`, clear `issued`, then go to BURST.
  - If all FIFOs are empty, stay in IDLE.
- **Issue in BURST.**
  - `re[sel]` = ~`empty[sel]` & `credit` & (`issued` < BURST).
  - `issued` increments on each `re`.
- **Burst end.** Leave BURST when either:
  - `issued`==BURST, or
  - `empty[sel]`=1 while `issued`≥1.
  
  On exit, `rr_ptr` ← (`sel`+1) mod N and the FSM returns to IDLE. A BURST entered with `empty[sel]`=1 and `issued`=0 exits the same way, which covers an empty that races the grant.
- **Credit.**
  - `occ` is the buffer occupancy, 0..2.
  - `infl` is `re` issued in the previous cycle.
  - `credit` = (`occ` + `infl` − (`out_valid`&`out_ready`)) < 2.
  - The buffer therefore never overflows.
- **Capture.** On the cycle after `re`, `rdata[sel_d]` and `sel_d` are written into the buffer tail. `sel_d` is `sel` delayed by one cycle.
- **Egress.**
  - `out_valid` = `occ`>0.
  - `out_data`/`out_src` are taken from the buffer head.
  - Pop on `out_valid`&`out_ready`.
  - Push and pop may occur in the same cycle.
- **Ordering.** Words from one FIFO are emitted in read order. Bursts are emitted in grant order.
- **Width rules.**
  - `issued` is $clog2(BURST+1) bits.
  - `rr_ptr`/`sel` are SW bits, with explicit wrap at N−1→0 (N need not be a power of two).

## Timing
- **Reset values:** `re`=0, `out_valid`=0, `out_data`=0, `out_src`=0, state=IDLE, `rr_ptr`=0, `occ`=0, `infl`=0.
- **Reset mid-burst:** in-flight and buffered words are discarded. The FIFOs must be reset together with this block.
- **Latency:**
  - Grant to first `re`: 1 cycle (the IDLE→BURST registration).
  - `re` at cycle t gives `out_valid` at t+2.
- **Throughput:** with `out_ready`=1, one word per cycle within a burst. Exactly one IDLE bubble between bursts.
- **Backpressure:** with `out_ready`=0, at most 2 words are held and `re` stops after the second. When ready returns, issue resumes the same cycle that credit reopens.
- **Empty race:** a FIFO holding one word sees `re` at t. Its `empty` rises at t+1, so no `re` is issued at t+1.

## Structure
- **Package `ldl_fifo_arb_pkg`:** the `state_t` enum {IDLE, BURST}, and a helper function `rr_next(ptr, n)` for modulo-N increment.
- **Sub-module `ldl_skid2`:** a 2-entry push/pop buffer carrying {src, data}, with the `occ` output used for credit.
- The top level holds the FSM, round-robin pointer, burst counter and credit logic.

## Test plan
- **Single source:** N=4, BURST=4. FIFO 2 holds 3 words (A,B,C), others empty, `out_ready`=1.
  - Expect `re[2]` for 3 consecutive cycles.
  - Egress A,B,C with `out_src`=2 on consecutive cycles.
  - Then IDLE, with `rr_ptr`=3.
- **Fairness:** all 4 FIFOs hold 10 words.
  - Expect bursts of exactly 4 from FIFO 0,1,2,3,0,… with one bubble between bursts.
  - No FIFO is starved.
- **Backpressure:** hold `out_ready`=0 during a burst from FIFO 1.
  - Exactly 2 `re` pulses, `out_valid`=1 holding the first word.
  - Release ready: the remaining 2 words follow with no loss or duplication.
- **Skip empties:** `rr_ptr`=1, only FIFO 0 non-empty.
  - Expect grant to FIFO 0 after wrap.
  - `rr_ptr`=1 after the burst ends.
- **Random soak:** random writes to all FIFOs and a random `out_ready`. A scoreboard checks per-source order, no loss, `re` only when `empty`=0, and `occ`≤2.
- **Mid-operation reset:** assert `rst` at any point.
  - Next cycle: `re`=0, `out_valid`=0, `rr_ptr`=0.
  - After deassertion, the first grant goes to the lowest-indexed non-empty FIFO.

Source files
------------

// File: rtl/ldl_fifo_arb_pkg.sv
// Purpose: shared types and helpers for the FIFO read arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t  - arbiter FSM state {IDLE, BURST}
//   rr_next  - modulo-n increment with explicit wrap, safe for non-power-of-two n
package ldl_fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Returns (ptr + 1) mod n without relying on power-of-two wrap.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/ldl_skid2.sv
// Purpose: 2-entry push/pop buffer that absorbs the RAM read latency for the arbiter.
// Latency: push at cycle t is visible at the head (vld_o) in cycle t+1.
// Backpressure: no internal stall; the producer must never push while two words are held.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   push_i        - write push_dat_i into the tail this cycle
//   push_dat_i    - entry payload ({src, data} in the arbiter)
//   pop_i         - consume the head entry (ignored when empty)
//   vld_o         - head entry is valid
//   head_o        - head entry payload (zero after reset)
//   occ_o         - current occupancy, 0..2
module ldl_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic         vld_o,
    output logic [W-1:0] head_o,
    output logic [1:0]   occ_o
);

    logic [1:0][W-1:0] mem_q;
    logic              wr_q;
    logic              rd_q;
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;
    logic              do_pop;

    assign do_pop = pop_i && (occ_q != 2'd0);
    assign occ_d  = occ_q + {1'b0, push_i} - {1'b0, do_pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            occ_q <= occ_d;
        end
    end

    assign vld_o  = (occ_q != 2'd0);
    assign head_o = mem_q[rd_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/ldl_fifo_rd_arb.sv
// Purpose: round-robin read scheduler sharing one valid/ready egress among N FIFO read-sides.
// Latency: grant to first re is 1 cycle; re at cycle t gives out_valid at t+2.
// Backpressure: credit holds re once buffer + in-flight words reach 2; no word is ever dropped.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset (FIFOs reset alongside)
//   empty      - per-FIFO registered empty flags
//   re         - per-FIFO read enable, one-hot or zero
//   rdata      - per-FIFO RAM read data, valid the cycle after re
//   out_valid  - egress word valid
//   out_ready  - egress accept
//   out_data   - egress word
//   out_src    - index of the FIFO that supplied out_data
module ldl_fifo_rd_arb
    import ldl_fifo_arb_pkg::*;
#(
    parameter int  N     = 4,
    parameter int  DW    = 32,
    parameter int  BURST = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         empty,
    output logic [N-1:0]         re,
    input  logic [N-1:0][DW-1:0] rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [SW-1:0]        out_src
);

    localparam int IW = $clog2(BURST + 1);
    localparam int BW = SW + DW;

    state_t          state_q;
    state_t          state_d;
    logic [SW-1:0]   sel_q;
    logic [SW-1:0]   sel_d;
    logic [SW-1:0]   rr_ptr_q;
    logic [SW-1:0]   rr_ptr_d;
    logic [IW-1:0]   issued_q;
    logic [IW-1:0]   issued_d;
    logic            infl_q;
    logic [SW-1:0]   sel_dly_q;

    logic            re_sel;
    logic            found;
    logic [SW-1:0]   pick;
    logic [SW-1:0]   scan_idx;

    logic [1:0]      occ;
    logic            pop;
    logic [2:0]      credit_sum;
    logic            credit;
    logic [BW-1:0]   push_dat;
    logic [BW-1:0]   head;

    // Scan starting at rr_ptr, wrapping explicitly so N need not be a power of two.
    always_comb begin
        found    = 1'b0;
        pick     = rr_ptr_q;
        scan_idx = rr_ptr_q;
        for (int i = 0; i < N; i++) begin
            if (!found && !empty[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
            scan_idx = SW'(rr_next(32'(scan_idx), N));
        end
    end

    // Words already held plus the one landing from last cycle's read, minus the
    // one leaving now, must stay below 2 for a new read to be safe.
    assign pop        = out_valid & out_ready;
    assign credit_sum = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
    assign credit     = (credit_sum < 3'd2);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        issued_d = issued_q;
        re_sel   = 1'b0;
        case (state_q)
            ldl_fifo_arb_pkg::IDLE: begin
                if (found) begin
                    sel_d    = pick;
                    issued_d = '0;
                    state_d  = ldl_fifo_arb_pkg::BURST;
                end
            end
            ldl_fifo_arb_pkg::BURST: begin
                re_sel   = !rst && !empty[sel_q] && credit && (issued_q < IW'(BURST));
                issued_d = issued_q + IW'(re_sel);
                // Leaving on the cycle of the last read keeps the gap between
                // full bursts to a single IDLE cycle. An empty seen at any point
                // (including a grant that raced the FIFO draining) ends the burst.
                if (empty[sel_q] || (issued_d == IW'(BURST))) begin
                    state_d  = ldl_fifo_arb_pkg::IDLE;
                    rr_ptr_d = SW'(rr_next(32'(sel_q), N));
                end
            end
            default: begin
                state_d = ldl_fifo_arb_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ldl_fifo_arb_pkg::IDLE;
            sel_q     <= '0;
            rr_ptr_q  <= '0;
            issued_q  <= '0;
            infl_q    <= 1'b0;
            sel_dly_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_ptr_q  <= rr_ptr_d;
            issued_q  <= issued_d;
            infl_q    <= re_sel;
            sel_dly_q <= sel_q;
        end
    end

    always_comb begin
        re = '0;
        if (re_sel) begin
            re[sel_q] = 1'b1;
        end
    end

    // RAM data arrives one cycle after re; tag it with the source that was read.
    assign push_dat = {sel_dly_q, rdata[sel_dly_q]};

    ldl_skid2 #(
        .W (BW)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_i     (infl_q),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .vld_o      (out_valid),
        .head_o     (head),
        .occ_o      (occ)
    );

    assign out_src  = head[BW-1:DW];
    assign out_data = head[DW-1:0];

endmodule

// File: tb/tb_ldl_fifo_rd_arb.sv
// Purpose: self-checking bench for ldl_fifo_rd_arb with behavioural FIFO read-sides.
// Latency: FIFO model gives rdata the cycle after re and registered empty flags.
// Backpressure: out_ready driven directly by the stimulus process.
module tb_ldl_fifo_rd_arb;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int BURST = 4;
    localparam int SW    = 2;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b1;
    logic [N-1:0]         empty     = '1;
    logic [N-1:0]         re;
    logic [N-1:0][DW-1:0] rdata     = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [DW-1:0]        out_data;
    logic [SW-1:0]        out_src;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    int load_cyc = 0;
    int soak_id  = 0;

    typedef logic [DW-1:0] wq_t[$];
    wq_t fifo_q[N];
    wq_t exp_q[N];
    int  exp_seq[$];
    int  re_cyc[$];
    int  out_cyc[$];
    int  re_cnt[N];

    ldl_fifo_rd_arb #(
        .N     (N),
        .DW    (DW),
        .BURST (BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .re        (re),
        .rdata     (rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        chk_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // FIFO read-side model: registered empty, RAM data valid the cycle after re.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) fifo_q[i].delete();
            empty <= '1;
            rdata <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (re[i] && fifo_q[i].size() != 0) rdata[i] <= fifo_q[i].pop_front();
                empty[i] <= (fifo_q[i].size() == 0);
            end
        end
    end

    // Monitor: compares egress against the scoreboard and watches re/occupancy.
    always @(negedge clk) begin
        if (!rst) begin
            check("occ_le_2", 64'(dut.u_skid.occ_o <= 2'd2), 64'd1);
            if (re != '0) begin
                check("re_onehot", 64'($onehot(re)), 64'd1);
                for (int i = 0; i < N; i++) begin
                    if (re[i]) begin
                        check("re_when_nonempty", 64'(empty[i]), 64'd0);
                        re_cnt[i]++;
                        re_cyc.push_back(cyc);
                    end
                end
            end
            if (out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                if (exp_q[out_src].size() == 0) begin
                    check("egress_unexpected_src", 64'(out_src), 64'hFF);
                end else begin
                    check("egress_data", 64'(out_data), 64'(exp_q[out_src].pop_front()));
                end
                if (exp_seq.size() != 0) check("egress_src_order", 64'(out_src), 64'(exp_seq.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int f, input logic [DW-1:0] w);
        fifo_q[f].push_back(w);
        exp_q[f].push_back(w);
    endtask

    function automatic bit sb_empty();
        for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (n < budget && !(sb_empty() && !out_valid)) begin
            tick(1);
            n++;
        end
        check({name, "_drain_in_budget"}, 64'(n < budget), 64'd1);
        tick(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            re_cnt[i] = 0;
        end
        exp_seq.delete();
        re_cyc.delete();
        out_cyc.delete();
        tick(1);
        check("rst_re", 64'(re), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
        check("rst_state", 64'(dut.state_q), 64'(ldl_fifo_arb_pkg::IDLE));
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(1);
        do_reset();

        // Single source: FIFO 2 holds A,B,C.
        load_cyc = cyc;
        load(2, 32'h0000_000A);
        load(2, 32'h0000_000B);
        load(2, 32'h0000_000C);
        repeat (3) exp_seq.push_back(2);
        wait_drain("single", 60);
        check("single_re_cnt", 64'(re_cnt[2]), 64'd3);
        check("single_out_cnt", 64'(out_cyc.size()), 64'd3);
        if (re_cyc.size() == 3 && out_cyc.size() == 3) begin
            check("single_grant_latency", 64'(re_cyc[0] - load_cyc), 64'd2);
            check("single_re_consecutive", 64'(re_cyc[2] - re_cyc[0]), 64'd2);
            check("single_re_to_valid", 64'(out_cyc[0] - re_cyc[0]), 64'd2);
            check("single_out_consecutive", 64'(out_cyc[2] - out_cyc[0]), 64'd2);
        end
        check("single_rr_ptr", 64'(dut.rr_ptr_q), 64'd3);
        check("single_state_idle", 64'(dut.state_q), 64'(ldl_fifo_arb_pkg::IDLE));

        // Fairness: all four FIFOs hold 10 words.
        do_reset();
        for (int f = 0; f < N; f++)
            for (int k = 0; k < 10; k++) load(f, 32'hF000_0000 | (f << 8) | k);
        for (int r = 0; r < 2; r++)
            for (int f = 0; f < N; f++) repeat (4) exp_seq.push_back(f);
        for (int f = 0; f < N; f++) repeat (2) exp_seq.push_back(f);
        wait_drain("fair", 300);
        for (int f = 0; f < N; f++) check("fair_re_cnt", 64'(re_cnt[f]), 64'd10);
        check("fair_seq_consumed", 64'(exp_seq.size()), 64'd0);
        check("fair_total_re", 64'(re_cyc.size()), 64'd40);
        if (re_cyc.size() == 40) begin
            // 8 full bursts: 32 reads plus 7 single-cycle bubbles.
            check("fair_full_burst_span", 64'(re_cyc[31] - re_cyc[0]), 64'd38);
            check("fair_one_bubble", 64'(re_cyc[4] - re_cyc[3]), 64'd2);
        end
        check("fair_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);

        // Backpressure during a burst from FIFO 1.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            load(1, 32'hB000_0000 | k);
            exp_seq.push_back(1);
        end
        tick(10);
        check("bp_re_cnt_held", 64'(re_cnt[1]), 64'd12);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_head_data", 64'(out_data), 64'hB000_0000);
        check("bp_head_src", 64'(out_src), 64'd1);
        check("bp_occ", 64'(dut.u_skid.occ_o), 64'd2);
        out_ready = 1'b1;
        wait_drain("bp", 60);
        check("bp_re_cnt_final", 64'(re_cnt[1]), 64'd14);
        check("bp_rr_ptr", 64'(dut.rr_ptr_q), 64'd2);

        // Skip empties: only FIFO 0 non-empty, scan wraps around.
        load(0, 32'hC000_0000);
        exp_seq.push_back(0);
        wait_drain("skip_a", 60);
        check("skip_a_rr_ptr", 64'(dut.rr_ptr_q), 64'd1);
        load(0, 32'hC000_0001);
        load(0, 32'hC000_0002);
        repeat (2) exp_seq.push_back(0);
        wait_drain("skip_b", 60);
        check("skip_b_rr_ptr", 64'(dut.rr_ptr_q), 64'd1);
        check("skip_re_cnt", 64'(re_cnt[0]), 64'd13);

        // Mid-operation reset with a full buffer and a burst in progress.
        out_ready = 1'b0;
        for (int f = 0; f < N; f++)
            for (int k = 0; k < 6; k++) load(f, 32'hD000_0000 | (f << 8) | k);
        tick(8);
        check("mid_out_valid_before_rst", 64'(out_valid), 64'd1);
        do_reset();
        out_ready = 1'b1;
        load(3, 32'hE000_0300);
        load(3, 32'hE000_0301);
        load(1, 32'hE000_0100);
        load(1, 32'hE000_0101);
        exp_seq.push_back(1);
        exp_seq.push_back(1);
        exp_seq.push_back(3);
        exp_seq.push_back(3);
        wait_drain("post_rst", 60);
        check("post_rst_seq_consumed", 64'(exp_seq.size()), 64'd0);

        // Random soak: random writes and random out_ready.
        for (int c = 0; c < 1500; c++) begin
            for (int f = 0; f < N; f++) begin
                if ($urandom_range(0, 9) == 0) begin
                    load(f, 32'h5000_0000 | (f << 20) | soak_id);
                    soak_id++;
                end
            end
            out_ready = ($urandom_range(0, 1) == 1);
            tick(1);
        end
        out_ready = 1'b1;
        wait_drain("soak", 4000);
        check("soak_state_idle", 64'(dut.state_q), 64'(ldl_fifo_arb_pkg::IDLE));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
